servo_pwm_capture: RTL

//  Receive end of the servo PWM link: measures an incoming servo/RC pulse train, reports high time and period.

---
 rtl/servo_pwm_pkg.sv | 43 ++++
 rtl/servo_pwm_capture_if.sv | 32 +++
 rtl/pwm_in_cond.sv | 89 ++++++++
 rtl/servo_pwm_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_pkg.sv
// Shared definitions for the servo PWM generator and capture blocks:
// FSM state encoding, tick counter width and saturation value, and
// small helpers for saturating counts and width range checking.
package servo_pwm_pkg;

    localparam int unsigned CNT_W = 16;

    typedef logic [CNT_W-1:0] tick_cnt_t;

    localparam tick_cnt_t TICK_SAT = 16'hFFFF;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } pwm_state_e;

    // One published measurement, as seen on the capture outputs.
    typedef struct packed {
        tick_cnt_t pulse_width;
        tick_cnt_t period;
        logic      range_err;
    } pwm_meas_t;

    // Increment that sticks at the saturation value instead of wrapping.
    function automatic tick_cnt_t sat_inc(input tick_cnt_t v);
        return (v == TICK_SAT) ? v : v + 1'b1;
    endfunction

    // High when v lies outside [lo, hi]. Uses the borrow of a widened
    // subtraction so that limits at 0 or 16'hFFFF do not turn into
    // constant comparisons.
    function automatic logic out_of_range(input tick_cnt_t v,
                                          input tick_cnt_t lo,
                                          input tick_cnt_t hi);
        logic below;
        logic above;
        below = 1'(({1'b0, v} - {1'b0, lo}) >> CNT_W);
        above = 1'(({1'b0, hi} - {1'b0, v}) >> CNT_W);
        return below | above;
    endfunction

endpackage

// File: rtl/servo_pwm_capture_if.sv
// Signal bundle of the servo PWM capture block: the raw PWM input and the
// measurement results. The capture block takes the master side, the
// consumer (and the bench) the slave side.
interface servo_pwm_capture_if;
    import servo_pwm_pkg::*;

    logic      pwm_in;
    tick_cnt_t pulse_width;
    tick_cnt_t period;
    logic      meas_valid;
    logic      range_err;
    logic      signal_ok;

    modport master (
        input  pwm_in,
        output pulse_width,
        output period,
        output meas_valid,
        output range_err,
        output signal_ok
    );

    modport slave (
        output pwm_in,
        input  pulse_width,
        input  period,
        input  meas_valid,
        input  range_err,
        input  signal_ok
    );

endinterface

// File: rtl/pwm_in_cond.sv
// Input conditioning for the PWM capture: two-flop synchronizer, optional
// glitch filter (enabled by defining PWM_CAP_FILTER_EN), and registered
// rise/fall detection. Strobes appear 3 clk after a pwm_i edge without the
// filter, FILT_LEN clk later with it. level_o is the level aligned with the
// strobes (it already shows the new level in a strobe cycle).
module pwm_in_cond
`ifdef PWM_CAP_FILTER_EN
#(
    parameter int unsigned FILT_LEN = 4
)
`endif
(
    input  logic clk,
    input  logic resetb,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q;
    logic sync2_q;
    logic lvl;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    // Two-flop synchronizer; left unreset so reset never fabricates an edge.
    always_ff @(posedge clk) begin
        sync1_q <= pwm_i;
        sync2_q <= sync1_q;
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int unsigned FCW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

    logic           filt_q;
    logic           filt_d;
    logic [FCW-1:0] fcnt_q;
    logic [FCW-1:0] fcnt_d;

    // Filtered level follows the synchronizer only after FILT_LEN equal samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync2_q != filt_q) begin
            if (fcnt_q == FCW'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Filter state; reset adopts the present input level.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            filt_q <= sync2_q;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync2_q;
`endif

    // Edge detect; reset loads the current level so a pulse in progress is
    // not reported as a new rise.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            prev_q <= lvl;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
            fall_q <= ~lvl & prev_q;
        end
    end

    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo PWM capture: measures high time and rise-to-rise period of the
// incoming pulse train in prescaled ticks (one tick per DIVCLK+1 clk).
// Optional glitch filter in the input path when PWM_CAP_FILTER_EN is defined.
module servo_pwm_capture
    import servo_pwm_pkg::*;
#(
    parameter int unsigned DIVCLK  = 6,
    parameter tick_cnt_t   TIMEOUT = 16'hFFF0,
    parameter tick_cnt_t   MIN_W   = 16'h0000,
    parameter tick_cnt_t   MAX_W   = 16'hFFFF
`ifdef PWM_CAP_FILTER_EN
    ,
    parameter int unsigned FILT_LEN = 4
`endif
) (
    input  logic                clk,
    input  logic                resetb,
    servo_pwm_capture_if.master cap_if
);

    localparam int unsigned PRESC_W = (DIVCLK < 2) ? 1 : $clog2(DIVCLK + 1);
    localparam logic [PRESC_W-1:0] PRESC_TERM = PRESC_W'(DIVCLK);
    // The rise cycle itself is prescaler slot 0, so the register resumes at
    // slot 1; this makes width = floor(high_clk / (DIVCLK+1)).
    localparam logic [PRESC_W-1:0] PRESC_AFTER_RISE = (DIVCLK == 0) ? '0 : PRESC_W'(1);

    logic level;
    logic rise;
    logic fall;
    logic rise_ev;
    logic fall_ev;

    pwm_in_cond
`ifdef PWM_CAP_FILTER_EN
    #(
        .FILT_LEN (FILT_LEN)
    )
`endif
    u_cond (
        .clk     (clk),
        .resetb  (resetb),
        .pwm_i   (cap_if.pwm_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // A strobe is only honoured when it agrees with the settled level.
    assign rise_ev = rise & level;
    assign fall_ev = fall & ~level;

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               tick;

    pwm_state_e state_q;
    pwm_state_e state_d;

    tick_cnt_t hi_cnt_q;
    tick_cnt_t hi_cnt_d;
    tick_cnt_t per_cnt_q;
    tick_cnt_t per_cnt_d;

    logic per_at_limit;
    logic timeout;
    logic publish;
    logic hi_inc;
    logic per_inc;
    logic cnt_clr;

    pwm_meas_t meas_q;
    pwm_meas_t meas_d;
    logic      meas_valid_q;
    logic      meas_valid_d;
    logic      signal_ok_q;
    logic      signal_ok_d;

    assign tick         = (presc_q == PRESC_TERM);
    assign per_at_limit = (per_cnt_q == TIMEOUT);

    // Prescaler: free-running 0..DIVCLK, realigned on every rise.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (rise_ev) begin
            presc_d = PRESC_AFTER_RISE;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= S_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: timeout beats any edge in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (rise_ev) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (per_at_limit) begin
                    state_d = S_WAIT;
                end else if (fall_ev) begin
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (per_at_limit) begin
                    state_d = S_WAIT;
                end else if (rise_ev) begin
                    state_d = S_HIGH;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    // FSM outputs. An edge swallows a coincident tick for the counter it
    // ends; the fall does not end the period, so per_cnt keeps that tick.
    always_comb begin
        timeout = 1'b0;
        publish = 1'b0;
        hi_inc  = 1'b0;
        per_inc = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            S_WAIT: begin
                cnt_clr = rise_ev;
            end
            S_HIGH: begin
                timeout = per_at_limit;
                hi_inc  = tick & ~fall_ev & ~per_at_limit;
                per_inc = tick & ~per_at_limit;
            end
            S_LOW: begin
                timeout = per_at_limit;
                publish = rise_ev & ~per_at_limit;
                cnt_clr = rise_ev & ~per_at_limit;
                per_inc = tick & ~rise_ev & ~per_at_limit;
            end
            default: ;
        endcase
    end

    // High-time and period counters, saturating, cleared by a rise.
    always_comb begin
        hi_cnt_d  = hi_cnt_q;
        per_cnt_d = per_cnt_q;
        if (cnt_clr) begin
            hi_cnt_d  = '0;
            per_cnt_d = '0;
        end else begin
            if (hi_inc) begin
                hi_cnt_d = sat_inc(hi_cnt_q);
            end
            if (per_inc) begin
                per_cnt_d = sat_inc(per_cnt_q);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            hi_cnt_q  <= '0;
            per_cnt_q <= '0;
        end else begin
            hi_cnt_q  <= hi_cnt_d;
            per_cnt_q <= per_cnt_d;
        end
    end

    // Result update: publish on a completed period, drop signal_ok on timeout.
    always_comb begin
        meas_d       = meas_q;
        signal_ok_d  = signal_ok_q;
        meas_valid_d = publish;
        if (publish) begin
            meas_d.pulse_width = hi_cnt_q;
            meas_d.period      = per_cnt_q;
            meas_d.range_err   = out_of_range(hi_cnt_q, MIN_W, MAX_W);
            signal_ok_d        = 1'b1;
        end else if (timeout) begin
            signal_ok_d = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            meas_q       <= '0;
            meas_valid_q <= 1'b0;
            signal_ok_q  <= 1'b0;
        end else begin
            meas_q       <= meas_d;
            meas_valid_q <= meas_valid_d;
            signal_ok_q  <= signal_ok_d;
        end
    end

    assign cap_if.pulse_width = meas_q.pulse_width;
    assign cap_if.period      = meas_q.period;
    assign cap_if.range_err   = meas_q.range_err;
    assign cap_if.meas_valid  = meas_valid_q;
    assign cap_if.signal_ok   = signal_ok_q;

endmodule
